pcm_fifo: RTL and testbench
===========================

PCM_FIFO -- requirements
Module: pcm_fifo

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits; matches the filter's Dout width.
REQ-002 Parameter DEPTH, default 8, number of sample entries; SHALL be a power of two and at least 2.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 Push  input  1  write strobe from the upstream filter; one sample per high cycle.
REQ-006 Din  input  WIDTH  signed PCM sample; sampled in every cycle where Push=1.
REQ-007 Pull  input  1  consumer ready; pops the head entry in any cycle where Valid=1.
REQ-008 ClrOvf  input  1  synchronous clear of Overflow and DropCnt.
REQ-009 Dout  output  WIDTH  head-of-queue sample (show-ahead); valid only while Valid=1.
REQ-010 Valid  output  1  queue non-empty.
REQ-011 Full  output  1  queue holds DEPTH entries.
REQ-012 Count  output  clog2(DEPTH)+1  current number of stored entries.
REQ-013 Overflow  output  1  sticky flag; set when a sample has been dropped.
REQ-014 DropCnt  output  8  number of dropped samples, saturating at 255.

Function
REQ-015 Storage SHALL be a DEPTH-entry register array with a write pointer and a read pointer, each clog2(DEPTH) bits wide, wrapping modulo DEPTH.
REQ-016 Write acceptance: accept when Push=1 and (Full=0, or Full=1 with Pull=1 in the same cycle); on acceptance write Din at the write pointer, then increment the write pointer.
REQ-017 Pop: when Pull=1 and Valid=1, increment the read pointer; Pull while Valid=0 SHALL have no effect.
REQ-018 Count update: next Count = Count + accepted write - pop. Simultaneous accepted write and pop leaves Count unchanged.
REQ-019 Valid = (Count != 0), Full = (Count == DEPTH), Dout = mem[read pointer]; all are combinational from registered state, with no added register stage.
REQ-020 Latency: a sample pushed into an empty queue at edge N SHALL appear on Dout with Valid=1 in the cycle after edge N.
REQ-021 Empty queue with Push and Pull asserted in the same cycle: Pull is ignored, the write is accepted, and Count becomes 1.
REQ-022 Drop: Push=1, Full=1 and Pull=0 SHALL discard Din, leave the array and pointers unchanged, set Overflow, and increment DropCnt unless it is already 255.
REQ-023 ClrOvf=1 SHALL clear Overflow and DropCnt on the next edge; if a drop occurs in the same cycle, the drop wins: Overflow=1 and DropCnt=1.
REQ-024 Dout SHALL be passed through bit-exact; no sign extension, rounding or reordering.
REQ-025 Sample order SHALL be strictly first-in first-out across pointer wrap-around.
REQ-026 Throughput: sustained push and pull at one sample per cycle SHALL cause no drops at any fill level from 1 to DEPTH.

Reset
REQ-027 On Reset assertion: pointers=0, Count=0, Valid=0, Full=0, Overflow=0, DropCnt=0, and Dout=0, with the array cleared to 0.
REQ-028 Reset asserted mid-operation SHALL discard all stored samples; the first post-reset Push SHALL be the first sample read.
REQ-029 While Reset=1, Push, Pull and ClrOvf SHALL be ignored.

Verification
REQ-030 Reset, push 0x1234 once, Pull=0 -> next cycle Valid=1, Dout=0x1234, Count=1.
REQ-031 Push 0x0001..0x0008 back-to-back, Pull=0 -> Full=1, Count=8; then Pull held high -> Dout reads 0x0001..0x0008 in order, then Valid=0.
REQ-032 Full queue, Push 0xAAAA with Pull=0 -> Overflow=1, DropCnt=1, Count=8, and 0xAAAA is never read out.
REQ-033 Full queue, Push 0x5555 with Pull=1 -> Count stays 8, no drop, and 0x5555 is read eighth after that pop.
REQ-034 Full queue, 300 pushes with Pull=0 -> DropCnt=255; then ClrOvf with a concurrent drop -> Overflow=1, DropCnt=1.
REQ-035 Five entries stored, assert Reset for 1 cycle -> Count=0, Valid=0; push 0x7FFF -> first read returns 0x7FFF.

Source files
------------

// File: rtl/pcm_fifo_if.sv
// pcm_fifo_if: push/pull handshake and status bundle between a PCM filter, the FIFO and its consumer.
interface pcm_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic                     push;
    logic [WIDTH-1:0]         din;
    logic                     pull;
    logic                     clr_ovf;
    logic [WIDTH-1:0]         dout;
    logic                     valid;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [7:0]               drop_cnt;

    modport master (
        output push, din, pull, clr_ovf,
        input  dout, valid, full, count, overflow, drop_cnt
    );

    modport slave (
        input  push, din, pull, clr_ovf,
        output dout, valid, full, count, overflow, drop_cnt
    );
endinterface

// File: rtl/pcm_fifo.sv
// pcm_fifo: show-ahead sample FIFO with drop-on-full, sticky overflow flag and saturating drop counter.
module pcm_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    pcm_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf;
    logic [7:0]       drops;
    logic             is_full;
    logic             pop;
    logic             wr;
    logic             drop;

    always_comb begin
        is_full = cnt == (AW+1)'(DEPTH);
        pop     = bus.pull && cnt != '0;
        // a full queue still accepts a write when the head leaves in the same cycle
        wr      = bus.push && (!is_full || bus.pull);
        drop    = bus.push && is_full && !bus.pull;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            drops  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= bus.din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
            if (drop) begin
                ovf   <= 1'b1;
                drops <= bus.clr_ovf ? 8'd1 : (drops == 8'hFF ? drops : drops + 8'd1);
            end else if (bus.clr_ovf) begin
                ovf   <= 1'b0;
                drops <= '0;
            end
        end
    end

    assign bus.dout     = mem[rd_ptr];
    assign bus.valid    = cnt != '0;
    assign bus.full     = is_full;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
    assign bus.drop_cnt = drops;
endmodule

// File: tb/tb_pcm_fifo.sv
// tb_pcm_fifo: directed vector table plus hand-written reset, saturation and clear sequences.
module tb_pcm_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic        push;
        logic [15:0] din;
        logic        pull;
        logic        clr;
        logic        valid;
        logic        full;
        logic [3:0]  count;
        logic [15:0] dout;
        logic        ovf;
        logic [7:0]  drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    pcm_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pcm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic p, logic [15:0] d, logic pl, logic c, logic v, logic f,
                                logic [3:0] n, logic [15:0] o, logic ov, logic [7:0] dr);
        vec_t r;
        r.push = p; r.din = d; r.pull = pl; r.clr = c;
        r.valid = v; r.full = f; r.count = n; r.dout = o; r.ovf = ov; r.drop = dr;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(logic p, logic [15:0] d, logic pl, logic c);
        bus.push = p; bus.din = d; bus.pull = pl; bus.clr_ovf = c;
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pull = 1'b0; bus.clr_ovf = 1'b0;
    endtask

    task automatic check_status(string tag, logic v, logic f, logic [3:0] n, logic ov, logic [7:0] dr);
        check({tag, " valid"}, 32'(bus.valid), 32'(v));
        check({tag, " full"}, 32'(bus.full), 32'(f));
        check({tag, " count"}, 32'(bus.count), 32'(n));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(ov));
        check({tag, " drop_cnt"}, 32'(bus.drop_cnt), 32'(dr));
    endtask

    initial begin
        bus.push = 1'b0; bus.din = '0; bus.pull = 1'b0; bus.clr_ovf = 1'b0;

        vecs.push_back(mk(1, 16'h1234, 0, 0, 1, 0, 1, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 16'h00AB, 1, 0, 1, 0, 1, 16'h00AB, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(1, 16'(k), 0, 0, 1, k == 8, 4'(k), 16'h0001, 0, 0));
        vecs.push_back(mk(1, 16'hAAAA, 0, 0, 1, 1, 8, 16'h0001, 1, 1));
        vecs.push_back(mk(1, 16'h5555, 1, 0, 1, 1, 8, 16'h0002, 1, 1));
        for (int k = 3; k <= 8; k++)
            vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 4'(10 - k), 16'(k), 1, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h5555, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 16'h0101, 0, 0, 1, 0, 1, 16'h0101, 0, 0));
        vecs.push_back(mk(1, 16'h0202, 0, 0, 1, 0, 2, 16'h0101, 0, 0));
        vecs.push_back(mk(1, 16'h0303, 0, 0, 1, 0, 3, 16'h0101, 0, 0));
        vecs.push_back(mk(1, 16'h0404, 1, 0, 1, 0, 3, 16'h0202, 0, 0));
        vecs.push_back(mk(1, 16'h0505, 1, 0, 1, 0, 3, 16'h0303, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 2, 16'h0404, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h0505, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 0, 0, 0, 0);
        check("reset dout", 32'(bus.dout), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].din, vecs[i].pull, vecs[i].clr);
            check_status($sformatf("vec%0d", i), vecs[i].valid, vecs[i].full, vecs[i].count,
                         vecs[i].ovf, vecs[i].drop);
            if (vecs[i].valid)
                check($sformatf("vec%0d dout", i), 32'(bus.dout), 32'(vecs[i].dout));
        end

        // saturating drop counter and clear-versus-drop priority
        for (int i = 0; i < 8; i++) step(1, 16'(16'h1000 + i), 0, 0);
        for (int i = 0; i < 300; i++) step(1, 16'hDEAD, 0, 0);
        check_status("sat", 1, 1, 8, 1, 8'hFF);
        step(1, 16'hBEEF, 0, 1);
        check_status("clr+drop", 1, 1, 8, 1, 1);
        step(0, 16'h0000, 0, 1);
        check_status("clr", 1, 1, 8, 0, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d dout", i), 32'(bus.dout), 32'(16'h1000 + i));
            step(0, 16'h0000, 1, 0);
        end
        check_status("drained", 0, 0, 0, 0, 0);

        // asynchronous reset mid-operation, with inputs ignored while held
        for (int i = 0; i < 5; i++) step(1, 16'(16'h2000 + i), 0, 0);
        check_status("five", 1, 0, 5, 0, 0);
        rst = 1'b1;
        #1;
        check_status("async rst", 0, 0, 0, 0, 0);
        check("async rst dout", 32'(bus.dout), 32'h0);
        step(1, 16'h3333, 1, 1);
        check_status("rst held", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1, 16'h7FFF, 0, 0);
        check_status("post rst", 1, 0, 1, 0, 0);
        check("post rst dout", 32'(bus.dout), 32'h7FFF);
        step(0, 16'h0000, 1, 0);
        check_status("post rst pop", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
